arch_map_table_seg: RTL and testbench
=====================================

Name: arch_map_table_seg

Overview:
Parametrised architectural map table with a configurable commit width and a configurable number of repair packets. It holds the committed logical-to-physical register mapping and resolves same-destination collisions across an arbitrary commit bundle. It returns the freed physical register per lane, initialises itself after reset, and streams its contents to the RMT in segments on recovery. It sits in retire, between the active list and the rename map table / speculative free list.

Parameters:
COMMIT_W, 4, commit lanes (1..8)
NUM_LOG, 34, logical registers (table depth)
LOG_W, 6, logical index width; 2^LOG_W >= NUM_LOG
PHYS_W, 7, physical tag width; 2^PHYS_W >= NUM_LOG
N_REPAIR, 4, repair packets per cycle

Ports:
clk  in  1  clock
resetRams_i  in  1  asynchronous, active-high reset
commit_valid_i  in  COMMIT_W  per-lane commit valid; lane 0 is oldest
lane_active_i  in  COMMIT_W  per-lane enable; inactive lanes are ignored entirely
commit_log_i  in  COMMIT_W*LOG_W  logical destination per lane
commit_phys_i  in  COMMIT_W*PHYS_W  new physical mapping per lane
freed_valid_o  out  COMMIT_W  freed-register valid per lane
freed_phys_o  out  COMMIT_W*PHYS_W  physical register released to the free list
recover_i  in  1  misprediction, violation or exception recovery request
repair_flag_o  out  1  high while repair packets are being driven
repair_valid_o  out  N_REPAIR  per-packet valid
repair_addr_o  out  N_REPAIR*LOG_W  repair logical address
repair_data_o  out  N_REPAIR*PHYS_W  repair physical mapping
repair_done_o  out  1  one-cycle pulse on the last repair cycle
cons_addr_i  in  LOG_W  consolidation read address
cons_data_o  out  PHYS_W  combinational read of table[cons_addr_i]
debug_addr_i  in  LOG_W  debug read address
debug_data_o  out  PHYS_W  combinational read of table[debug_addr_i]
ready_o  out  1  table initialised and accepting commits

Behaviour:
- Constants: NRC = ceil(NUM_LOG/N_REPAIR). Packet p base = p*NRC. The counter is wide enough to hold NRC without overflow.
- States: INIT, IDLE, REPAIR. resetRams_i forces INIT with init pointer 0, counter 0 and pending 0. Reset mid-REPAIR abandons the repair.
- INIT:
  - Each cycle writes table[ptr] = ptr and increments ptr.
  - After ptr == NUM_LOG-1 is written, the next state is IDLE.
  - INIT lasts exactly NUM_LOG cycles after reset deasserts. ready_o = 1 only in IDLE/REPAIR.
- Reset and INIT values of outputs: freed_valid_o, repair_flag_o, repair_valid_o, repair_done_o and ready_o are all 0.
- Commit accept rule: lane i is effective when commit_valid_i[i] & lane_active_i[i] & (state == IDLE). Non-effective lanes write nothing and drive freed_valid_o[i] = 0.
- Collision resolution:
  - kill[i] = 1 if any younger effective lane j > i has the same logical destination.
  - An effective, non-killed lane writes table[log] = phys at the clock edge.
  - freed_phys_o[i] = kill[i] ? commit_phys_i[i] : table[log_i] (pre-write contents).
  - freed_valid_o[i] = effective[i]. Freed outputs are combinational, 0-cycle.
- recover_i in IDLE at cycle T:
  - Commits at T still apply.
  - REPAIR occupies cycles T+1..T+NRC, with counter c = 0..NRC-1.
  - Packet p: addr = base_p + c, valid = addr < NUM_LOG, data = table[addr] combinational.
  - Invalid packets drive addr and data 0.
  - repair_flag_o = 1 throughout REPAIR. repair_done_o = 1 when c == NRC-1, then the state returns to IDLE with the counter cleared.
- recover_i during REPAIR: the counter restarts at 0 on the next cycle (full re-sweep). The done pulse is suppressed for that cycle.
- recover_i during INIT: sets pending. REPAIR begins the cycle after INIT completes.

Test Plan:
1. Deassert resetRams_i -> ready_o low for exactly 34 cycles then high; debug_addr_i=5 -> debug_data_o=5; debug_addr_i=33 -> 33.
2. IDLE, 4 lanes valid with commit_log_i all 3 and phys 40,41,42,43 -> freed_phys_o = 40,41,42,3, all valid; next cycle table[3] = 43.
3. Lanes 0 and 2 valid, both log 7, phys 50,51, lane_active_i = 4'b1011 -> table[7] = 50; freed lane0 = 7; freed_valid_o[2] = 0.
4. recover_i pulse at T:
   - repair_flag_o high T+1..T+9.
   - Packet 0 addresses 0..8; packet 3 addresses 27..33 valid, then invalid for c = 7,8.
   - repair_done_o at T+9 only.
5. recover_i at T, again at T+4 -> counter back to 0 at T+5; repair_done_o at T+13 only; flag continuous T+1..T+13.
6. Commit log 2 phys 60 with recover_i in the same cycle T -> at T+3 packet 0 shows addr 2, data 60. Asserting resetRams_i at T+5 -> flag drops, ready_o = 0, INIT restarts.

Source files
------------

// File: rtl/arch_map_table_seg.sv
// Architectural (committed) logical-to-physical map table for the retire stage.
// Resolves same-destination collisions per commit bundle and streams its contents to the RMT on recovery.
module arch_map_table_seg #(
    parameter int COMMIT_W = 4,
    parameter int NUM_LOG  = 34,
    parameter int LOG_W    = 6,
    parameter int PHYS_W   = 7,
    parameter int N_REPAIR = 4
) (
    input  logic                         clk,
    input  logic                         resetRams_i,
    input  logic [COMMIT_W-1:0]          commit_valid_i,
    input  logic [COMMIT_W-1:0]          lane_active_i,
    input  logic [COMMIT_W*LOG_W-1:0]    commit_log_i,
    input  logic [COMMIT_W*PHYS_W-1:0]   commit_phys_i,
    output logic [COMMIT_W-1:0]          freed_valid_o,
    output logic [COMMIT_W*PHYS_W-1:0]   freed_phys_o,
    input  logic                         recover_i,
    output logic                         repair_flag_o,
    output logic [N_REPAIR-1:0]          repair_valid_o,
    output logic [N_REPAIR*LOG_W-1:0]    repair_addr_o,
    output logic [N_REPAIR*PHYS_W-1:0]   repair_data_o,
    output logic                         repair_done_o,
    input  logic [LOG_W-1:0]             cons_addr_i,
    output logic [PHYS_W-1:0]            cons_data_o,
    input  logic [LOG_W-1:0]             debug_addr_i,
    output logic [PHYS_W-1:0]            debug_data_o,
    output logic                         ready_o
);
    localparam int NRC   = (NUM_LOG + N_REPAIR - 1) / N_REPAIR;
    localparam int CNT_W = $clog2(NRC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NRC - 1);
    localparam logic [LOG_W-1:0] LAST_PTR = LOG_W'(NUM_LOG - 1);
    localparam logic [LOG_W:0]   DEPTH    = (LOG_W + 1)'(NUM_LOG);

    typedef enum logic [1:0] {INIT, IDLE, REPAIR} state_t;

    state_t            state, stateNext;
    logic [LOG_W-1:0]  initPtr, initPtrNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic              pending, pendingNext;
    logic [PHYS_W-1:0] mapTable [NUM_LOG];

    logic [LOG_W-1:0]  laneLog  [COMMIT_W];
    logic [PHYS_W-1:0] lanePhys [COMMIT_W];
    logic [COMMIT_W-1:0] effective, kill;
    logic [LOG_W:0]    repAddr;

    function automatic logic inRange(input logic [LOG_W-1:0] a);
        return {1'b0, a} < DEPTH;
    endfunction

    always_ff @(posedge clk or posedge resetRams_i) begin
        if (resetRams_i) begin
            state   <= INIT;
            initPtr <= '0;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            state   <= stateNext;
            initPtr <= initPtrNext;
            cnt     <= cntNext;
            pending <= pendingNext;
        end
    end

    always_comb begin
        stateNext     = state;
        initPtrNext   = initPtr;
        cntNext       = cnt;
        pendingNext   = pending;
        repair_done_o = 1'b0;
        case (state)
            INIT: begin
                initPtrNext = initPtr + 1'b1;
                pendingNext = pending | recover_i;
                if (initPtr == LAST_PTR) begin
                    // A recovery requested during init is served right after the last init write.
                    initPtrNext = '0;
                    pendingNext = 1'b0;
                    cntNext     = '0;
                    stateNext   = (pending | recover_i) ? REPAIR : IDLE;
                end
            end
            IDLE: begin
                if (recover_i) begin
                    stateNext = REPAIR;
                    cntNext   = '0;
                end
            end
            REPAIR: begin
                if (recover_i) begin
                    cntNext = '0;
                end else if (cnt == LAST_CNT) begin
                    repair_done_o = 1'b1;
                    stateNext     = IDLE;
                    cntNext       = '0;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            default: stateNext = INIT;
        endcase
    end

    always_comb begin
        for (int i = 0; i < COMMIT_W; i++) begin
            laneLog[i]   = commit_log_i[i*LOG_W +: LOG_W];
            lanePhys[i]  = commit_phys_i[i*PHYS_W +: PHYS_W];
            effective[i] = commit_valid_i[i] & lane_active_i[i] & (state == IDLE);
        end
    end

    // A lane is overwritten by any younger effective lane targeting the same register.
    always_comb begin
        for (int i = 0; i < COMMIT_W; i++) begin
            kill[i] = 1'b0;
            for (int j = i + 1; j < COMMIT_W; j++) begin
                if (effective[j] && (laneLog[j] == laneLog[i])) kill[i] = 1'b1;
            end
        end
    end

    always_comb begin
        freed_valid_o = effective;
        freed_phys_o  = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (kill[i])
                freed_phys_o[i*PHYS_W +: PHYS_W] = lanePhys[i];
            else if (inRange(laneLog[i]))
                freed_phys_o[i*PHYS_W +: PHYS_W] = mapTable[laneLog[i]];
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mapTable[initPtr] <= PHYS_W'(initPtr);
        end else begin
            for (int i = 0; i < COMMIT_W; i++) begin
                if (effective[i] && !kill[i] && inRange(laneLog[i]))
                    mapTable[laneLog[i]] <= lanePhys[i];
            end
        end
    end

    always_comb begin
        repair_flag_o  = (state == REPAIR);
        repair_valid_o = '0;
        repair_addr_o  = '0;
        repair_data_o  = '0;
        repAddr        = '0;
        if (state == REPAIR) begin
            for (int p = 0; p < N_REPAIR; p++) begin
                repAddr = (LOG_W + 1)'(p * NRC) + (LOG_W + 1)'(cnt);
                if (repAddr < DEPTH) begin
                    repair_valid_o[p]                 = 1'b1;
                    repair_addr_o[p*LOG_W +: LOG_W]   = repAddr[LOG_W-1:0];
                    repair_data_o[p*PHYS_W +: PHYS_W] = mapTable[repAddr[LOG_W-1:0]];
                end
            end
        end
    end

    assign cons_data_o  = inRange(cons_addr_i)  ? mapTable[cons_addr_i]  : '0;
    assign debug_data_o = inRange(debug_addr_i) ? mapTable[debug_addr_i] : '0;
    assign ready_o      = (state != INIT);
endmodule

// File: tb/tb_arch_map_table_seg.sv
// Directed bench for arch_map_table_seg: init sweep, commit collisions, repair streaming,
// re-sweep on repeated recovery, pending recovery during init and reset mid-repair.
module tb_arch_map_table_seg;
    logic        clk = 1'b0;
    logic        resetRams_i;
    logic [3:0]  commit_valid_i, lane_active_i;
    logic [23:0] commit_log_i;
    logic [27:0] commit_phys_i;
    logic [3:0]  freed_valid_o;
    logic [27:0] freed_phys_o;
    logic        recover_i;
    logic        repair_flag_o;
    logic [3:0]  repair_valid_o;
    logic [23:0] repair_addr_o;
    logic [27:0] repair_data_o;
    logic        repair_done_o;
    logic [5:0]  cons_addr_i, debug_addr_i;
    logic [6:0]  cons_data_o, debug_data_o;
    logic        ready_o;

    int nCompared = 0;
    int nMismatch = 0;
    int expTbl [34];
    int n;
    int expC;

    arch_map_table_seg dut (
        .clk(clk), .resetRams_i(resetRams_i),
        .commit_valid_i(commit_valid_i), .lane_active_i(lane_active_i),
        .commit_log_i(commit_log_i), .commit_phys_i(commit_phys_i),
        .freed_valid_o(freed_valid_o), .freed_phys_o(freed_phys_o),
        .recover_i(recover_i), .repair_flag_o(repair_flag_o),
        .repair_valid_o(repair_valid_o), .repair_addr_o(repair_addr_o),
        .repair_data_o(repair_data_o), .repair_done_o(repair_done_o),
        .cons_addr_i(cons_addr_i), .cons_data_o(cons_data_o),
        .debug_addr_i(debug_addr_i), .debug_data_o(debug_data_o),
        .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        commit_valid_i = '0;
        lane_active_i  = '0;
        commit_log_i   = '0;
        commit_phys_i  = '0;
        recover_i      = 1'b0;
    endtask

    initial begin
        resetRams_i  = 1'b1;
        clearInputs();
        cons_addr_i  = '0;
        debug_addr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready_o), 0);
        check("rst_freed_valid", 32'(freed_valid_o), 0);
        check("rst_flag", 32'(repair_flag_o), 0);
        check("rst_rvalid", 32'(repair_valid_o), 0);
        check("rst_done", 32'(repair_done_o), 0);

        // Init sweep length
        resetRams_i = 1'b0;
        n = 0;
        while (!ready_o && n < 100) begin
            tick();
            n++;
        end
        check("init_len", 32'(n), 34);
        for (int i = 0; i < 34; i++) expTbl[i] = i;
        debug_addr_i = 6'd5;  #1; check("dbg5", 32'(debug_data_o), 5);
        debug_addr_i = 6'd33; #1; check("dbg33", 32'(debug_data_o), 33);
        cons_addr_i  = 6'd20; #1; check("cons20", 32'(cons_data_o), 20);
        check("idle_flag", 32'(repair_flag_o), 0);

        // Four lanes all to log 3
        commit_valid_i = 4'hF;
        lane_active_i  = 4'hF;
        commit_log_i   = {6'd3, 6'd3, 6'd3, 6'd3};
        commit_phys_i  = {7'd43, 7'd42, 7'd41, 7'd40};
        #1;
        check("coll_fvalid", 32'(freed_valid_o), 32'hF);
        check("coll_fphys", 32'(freed_phys_o), 32'({7'd3, 7'd42, 7'd41, 7'd40}));
        tick();
        clearInputs();
        expTbl[3] = 43;
        debug_addr_i = 6'd3; #1; check("tbl3", 32'(debug_data_o), 43);

        // Inactive younger lane must not kill or write
        commit_valid_i = 4'b0101;
        lane_active_i  = 4'b1011;
        commit_log_i   = {6'd0, 6'd7, 6'd0, 6'd7};
        commit_phys_i  = {7'd0, 7'd51, 7'd0, 7'd50};
        #1;
        check("inact_fvalid", 32'(freed_valid_o), 32'b0001);
        check("inact_fphys0", 32'(freed_phys_o[6:0]), 7);
        tick();
        clearInputs();
        expTbl[7] = 50;
        debug_addr_i = 6'd7; #1; check("tbl7", 32'(debug_data_o), 50);

        // Single recovery: 9 repair cycles
        recover_i = 1'b1;
        tick();
        recover_i = 1'b0;
        commit_valid_i = 4'b0001;
        lane_active_i  = 4'b0001;
        commit_log_i   = 24'd5;
        commit_phys_i  = 28'd99;
        #1;
        check("rep_no_commit", 32'(freed_valid_o), 0);
        for (int c = 0; c < 9; c++) begin
            check("rep_flag", 32'(repair_flag_o), 1);
            check("rep_ready", 32'(ready_o), 1);
            check("rep_p0_valid", 32'(repair_valid_o[0]), 1);
            check("rep_p0_addr", 32'(repair_addr_o[5:0]), 32'(c));
            check("rep_p0_data", 32'(repair_data_o[6:0]), 32'(expTbl[c]));
            check("rep_p1_addr", 32'(repair_addr_o[11:6]), 32'(9 + c));
            if (c < 7) begin
                check("rep_p3_valid", 32'(repair_valid_o[3]), 1);
                check("rep_p3_addr", 32'(repair_addr_o[23:18]), 32'(27 + c));
                check("rep_p3_data", 32'(repair_data_o[27:21]), 32'(expTbl[27 + c]));
            end else begin
                check("rep_p3_inval", 32'(repair_valid_o[3]), 0);
                check("rep_p3_addr0", 32'(repair_addr_o[23:18]), 0);
                check("rep_p3_data0", 32'(repair_data_o[27:21]), 0);
            end
            check("rep_done", 32'(repair_done_o), (c == 8) ? 1 : 0);
            tick();
            clearInputs();
        end
        check("rep_end_flag", 32'(repair_flag_o), 0);
        check("rep_end_done", 32'(repair_done_o), 0);
        check("rep_end_rvalid", 32'(repair_valid_o), 0);
        debug_addr_i = 6'd5; #1; check("rep_blocked_write", 32'(debug_data_o), 5);

        // Second recovery mid-repair restarts the sweep
        recover_i = 1'b1;
        tick();
        for (int k = 1; k <= 13; k++) begin
            recover_i = (k == 4);
            #1;
            expC = (k <= 4) ? k - 1 : k - 5;
            check("resw_flag", 32'(repair_flag_o), 1);
            check("resw_cnt", 32'(repair_addr_o[5:0]), 32'(expC));
            check("resw_done", 32'(repair_done_o), (k == 13) ? 1 : 0);
            tick();
        end
        recover_i = 1'b0;
        #1;
        check("resw_end_flag", 32'(repair_flag_o), 0);

        // Commit and recovery in the same cycle
        commit_valid_i = 4'b0001;
        lane_active_i  = 4'b0001;
        commit_log_i   = 24'd2;
        commit_phys_i  = 28'd60;
        recover_i      = 1'b1;
        #1;
        check("cr_fvalid", 32'(freed_valid_o), 1);
        check("cr_fphys", 32'(freed_phys_o[6:0]), 2);
        tick();
        clearInputs();
        tick();
        tick();
        check("cr_p0_addr", 32'(repair_addr_o[5:0]), 2);
        check("cr_p0_data", 32'(repair_data_o[6:0]), 60);
        tick();
        tick();

        // Reset mid-repair abandons it and restarts init
        resetRams_i = 1'b1;
        #1;
        check("mr_flag", 32'(repair_flag_o), 0);
        check("mr_ready", 32'(ready_o), 0);
        check("mr_rvalid", 32'(repair_valid_o), 0);
        tick();
        resetRams_i = 1'b0;

        // Recovery during init is held until init finishes
        recover_i = 1'b1;
        tick();
        recover_i = 1'b0;
        n = 1;
        while (!ready_o && n < 100) begin
            tick();
            n++;
        end
        check("reinit_len", 32'(n), 34);
        check("pend_flag", 32'(repair_flag_o), 1);
        check("pend_p0_addr", 32'(repair_addr_o[5:0]), 0);
        debug_addr_i = 6'd2; #1; check("reinit_tbl2", 32'(debug_data_o), 2);
        n = 1;
        while (!repair_done_o && n < 50) begin
            tick();
            n++;
        end
        check("pend_done_cycle", 32'(n), 9);
        tick();
        check("pend_end_flag", 32'(repair_flag_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
